// File: rtl/multicycle_mux_ctrl.sv
// Multi-cycle control FSM for a 32-bit single-bus datapath.
// It sequences FETCH/DECODE and the per-opcode execute states, and drives every datapath
// MUX select and write enable as a combinational function of state (Mealy where noted).
// It counts retired instructions and flags illegal opcodes and memory handshake timeouts.
module multicycle_mux_ctrl #(
    parameter bit          ADDI_EN      = 1'b1,
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
    input  logic        Mem_Ready,
    output logic        PC_Write,
    output logic        IR_Write,
    output logic        IorD,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        ALU_SrcA,
    output logic [1:0]  ALU_SrcB,
    output logic [1:0]  ALU_Op,
    output logic        Mem_To_Reg,
    output logic        Reg_Dst,
    output logic        Reg_Write,
    output logic [1:0]  PC_Source,
    output logic        Illegal_Op,
    output logic        Mem_Fault,
    output logic [31:0] Instr_Count
);

    localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_s;
    logic [31:0]         instr_cnt_r;
    logic                retire_s;
    logic                timeout_s;

    logic                pc_write_s;
    logic                ir_write_s;
    logic                iord_s;
    logic                mem_read_s;
    logic                mem_write_s;
    logic                alu_src_a_s;
    logic [1:0]          alu_src_b_s;
    logic [1:0]          alu_op_s;
    logic                mem_to_reg_s;
    logic                reg_dst_s;
    logic                reg_write_s;
    logic [1:0]          pc_source_s;
    logic                illegal_op_s;
    logic                mem_fault_s;

    // State register, memory wait counter and retired-instruction counter.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_r     <= S_FETCH;
            wait_cnt_r  <= '0;
            instr_cnt_r <= 32'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            if (retire_s) begin
                instr_cnt_r <= instr_cnt_r + 32'd1;
            end else begin
                instr_cnt_r <= instr_cnt_r;
            end
        end
    end

    // Next-state, wait-counter update and datapath controls decoded from the current state.
    always_comb begin
        state_s      = state_r;
        wait_cnt_s   = '0;
        retire_s     = 1'b0;
        timeout_s    = (wait_cnt_r == WAIT_LIMIT) && !Mem_Ready;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'd0;
        alu_op_s     = 2'd0;
        mem_to_reg_s = 1'b0;
        reg_dst_s    = 1'b0;
        reg_write_s  = 1'b0;
        pc_source_s  = 2'd0;
        illegal_op_s = 1'b0;
        mem_fault_s  = 1'b0;

        case (state_r)
            S_FETCH: begin
                alu_src_b_s = 2'd1;
                if (timeout_s) begin
                    // Abandon the fetch: no request or enable on the fault cycle.
                    mem_fault_s = 1'b1;
                    state_s     = S_FETCH;
                end else begin
                    mem_read_s = 1'b1;
                    pc_write_s = Mem_Ready;
                    ir_write_s = Mem_Ready;
                    if (Mem_Ready) begin
                        state_s = S_DECODE;
                    end else begin
                        wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                alu_src_b_s = 2'd3;
                case (Opcode)
                    OP_RTYPE: state_s = S_EXEC_R;
                    OP_LW:    state_s = S_MEM_ADDR;
                    OP_SW:    state_s = S_MEM_ADDR;
                    OP_BEQ:   state_s = S_BRANCH;
                    OP_J:     state_s = S_JUMP;
                    OP_ADDI: begin
                        if (ADDI_EN) begin
                            state_s = S_ADDI_EX;
                        end else begin
                            illegal_op_s = 1'b1;
                            state_s      = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_op_s = 1'b1;
                        state_s      = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'd2;
                if (Opcode == OP_LW) begin
                    state_s = S_MEM_RD;
                end else begin
                    state_s = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                iord_s = 1'b1;
                if (timeout_s) begin
                    mem_fault_s = 1'b1;
                    state_s     = S_FETCH;
                end else begin
                    mem_read_s = 1'b1;
                    if (Mem_Ready) begin
                        state_s = S_MEM_WB;
                    end else begin
                        wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                state_s      = S_FETCH;
                retire_s     = 1'b1;
            end
            S_MEM_WR: begin
                iord_s = 1'b1;
                if (timeout_s) begin
                    mem_fault_s = 1'b1;
                    state_s     = S_FETCH;
                end else begin
                    mem_write_s = 1'b1;
                    if (Mem_Ready) begin
                        state_s  = S_FETCH;
                        retire_s = 1'b1;
                    end else begin
                        wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end
            end
            S_EXEC_R: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'd2;
                state_s     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
                state_s     = S_FETCH;
                retire_s    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'd1;
                pc_source_s = 2'd1;
                pc_write_s  = Zero;
                state_s     = S_FETCH;
                retire_s    = 1'b1;
            end
            S_JUMP: begin
                pc_source_s = 2'd2;
                pc_write_s  = 1'b1;
                state_s     = S_FETCH;
                retire_s    = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'd2;
                state_s     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_s = 1'b1;
                state_s     = S_FETCH;
                retire_s    = 1'b1;
            end
            default: begin
                state_s = S_FETCH;
            end
        endcase
    end

    // While Reset is low every control is forced to 0, including the selects.
    always_comb begin
        if (Reset) begin
            PC_Write   = pc_write_s;
            IR_Write   = ir_write_s;
            IorD       = iord_s;
            Mem_Read   = mem_read_s;
            Mem_Write  = mem_write_s;
            ALU_SrcA   = alu_src_a_s;
            ALU_SrcB   = alu_src_b_s;
            ALU_Op     = alu_op_s;
            Mem_To_Reg = mem_to_reg_s;
            Reg_Dst    = reg_dst_s;
            Reg_Write  = reg_write_s;
            PC_Source  = pc_source_s;
            Illegal_Op = illegal_op_s;
            Mem_Fault  = mem_fault_s;
        end else begin
            PC_Write   = 1'b0;
            IR_Write   = 1'b0;
            IorD       = 1'b0;
            Mem_Read   = 1'b0;
            Mem_Write  = 1'b0;
            ALU_SrcA   = 1'b0;
            ALU_SrcB   = 2'd0;
            ALU_Op     = 2'd0;
            Mem_To_Reg = 1'b0;
            Reg_Dst    = 1'b0;
            Reg_Write  = 1'b0;
            PC_Source  = 2'd0;
            Illegal_Op = 1'b0;
            Mem_Fault  = 1'b0;
        end
    end

    assign Instr_Count = instr_cnt_r;

endmodule

// File: tb/tb_multicycle_mux_ctrl.sv
// Directed bench for multicycle_mux_ctrl: walks each instruction class cycle by cycle and
// compares the full control vector against hand-written per-state constants.
module tb_multicycle_mux_ctrl;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [5:0]  Opcode;
    logic        Zero;
    logic        Mem_Ready;
    logic        PC_Write, IR_Write, IorD, Mem_Read, Mem_Write, ALU_SrcA;
    logic [1:0]  ALU_SrcB, ALU_Op, PC_Source;
    logic        Mem_To_Reg, Reg_Dst, Reg_Write, Illegal_Op, Mem_Fault;
    logic [31:0] Instr_Count;
    logic [16:0] ctl;

    int n_total = 0;
    int n_bad   = 0;

    multicycle_mux_ctrl #(.ADDI_EN(1'b1), .MEM_WAIT_MAX(4)) dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .PC_Write(PC_Write), .IR_Write(IR_Write), .IorD(IorD), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op),
        .Mem_To_Reg(Mem_To_Reg), .Reg_Dst(Reg_Dst), .Reg_Write(Reg_Write),
        .PC_Source(PC_Source), .Illegal_Op(Illegal_Op), .Mem_Fault(Mem_Fault),
        .Instr_Count(Instr_Count)
    );

    always #5 Clock = ~Clock;

    // {PC_Write,IR_Write,IorD,Mem_Read,Mem_Write,ALU_SrcA,ALU_SrcB,ALU_Op,Mem_To_Reg,Reg_Dst,Reg_Write,PC_Source,Illegal_Op,Mem_Fault}
    assign ctl = {PC_Write, IR_Write, IorD, Mem_Read, Mem_Write, ALU_SrcA, ALU_SrcB, ALU_Op,
                  Mem_To_Reg, Reg_Dst, Reg_Write, PC_Source, Illegal_Op, Mem_Fault};

    localparam logic [16:0] C_ZERO   = 17'd0;
    localparam logic [16:0] C_FETCH  = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'd1,2'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_FETCHW = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd1,2'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0};
    localparam logic [16:0] C_MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_MRD    = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,1'b0,1'b1,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_MWR    = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_EXR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd2,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,1'b1,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_BR1    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,1'b0,1'b0,1'b0,2'd1,1'b0,1'b0};
    localparam logic [16:0] C_BR0    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,1'b0,1'b0,1'b0,2'd1,1'b0,1'b0};
    localparam logic [16:0] C_JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,2'd2,1'b0,1'b0};
    localparam logic [16:0] C_AEX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0};
    localparam logic [16:0] C_AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0};

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Applies one cycle of inputs, checks the controls and the exclusivity rules, then steps the clock.
    task automatic run_cycle(input string tag, input logic [5:0] op, input logic z,
                             input logic rdy, input logic [16:0] exp);
        Opcode    = op;
        Zero      = z;
        Mem_Ready = rdy;
        #1;
        check_val(tag, {15'd0, ctl}, {15'd0, exp});
        check_val({tag, "_excl"}, {30'd0, Mem_Read & Mem_Write, Reg_Write & PC_Write}, 32'd0);
        @(posedge Clock);
        #1;
    endtask

    // Time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        Reset     = 1'b0;
        Opcode    = OP_LW;
        Zero      = 1'b0;
        Mem_Ready = 1'b1;

        // Two reset cycles with Mem_Ready high: every control must be 0.
        @(posedge Clock); #1;
        check_val("rst_c1", {15'd0, ctl}, 32'd0);
        @(posedge Clock); #1;
        check_val("rst_c2", {15'd0, ctl}, 32'd0);
        Reset = 1'b1;
        check_val("rst_cnt", Instr_Count, 32'd0);

        // lw: five cycles.
        run_cycle("lw_fetch", OP_LW, 1'b0, 1'b1, C_FETCH);
        run_cycle("lw_dec",   OP_LW, 1'b0, 1'b1, C_DEC);
        run_cycle("lw_addr",  OP_LW, 1'b0, 1'b1, C_MADDR);
        run_cycle("lw_rd",    OP_LW, 1'b0, 1'b1, C_MRD);
        run_cycle("lw_wb",    OP_LW, 1'b0, 1'b1, C_MWB);
        check_val("lw_cnt", Instr_Count, 32'd1);

        // beq taken, then not taken.
        run_cycle("beq1_fetch", OP_BEQ, 1'b1, 1'b1, C_FETCH);
        run_cycle("beq1_dec",   OP_BEQ, 1'b1, 1'b1, C_DEC);
        run_cycle("beq1_br",    OP_BEQ, 1'b1, 1'b1, C_BR1);
        check_val("beq1_cnt", Instr_Count, 32'd2);
        run_cycle("beq0_fetch", OP_BEQ, 1'b0, 1'b1, C_FETCH);
        run_cycle("beq0_dec",   OP_BEQ, 1'b0, 1'b1, C_DEC);
        run_cycle("beq0_br",    OP_BEQ, 1'b0, 1'b1, C_BR0);
        check_val("beq0_cnt", Instr_Count, 32'd3);

        // Illegal opcode: pulse in DECODE, straight back to FETCH, no retire.
        run_cycle("ill_fetch", OP_BAD, 1'b0, 1'b1, C_FETCH);
        run_cycle("ill_dec",   OP_BAD, 1'b0, 1'b1, C_DECILL);
        check_val("ill_cnt", Instr_Count, 32'd3);

        // R-type.
        run_cycle("r_fetch", OP_R, 1'b0, 1'b1, C_FETCH);
        run_cycle("r_dec",   OP_R, 1'b0, 1'b1, C_DEC);
        run_cycle("r_exec",  OP_R, 1'b0, 1'b1, C_EXR);
        run_cycle("r_wb",    OP_R, 1'b0, 1'b1, C_RWB);
        check_val("r_cnt", Instr_Count, 32'd4);

        // Jump.
        run_cycle("j_fetch", OP_J, 1'b0, 1'b1, C_FETCH);
        run_cycle("j_dec",   OP_J, 1'b0, 1'b1, C_DEC);
        run_cycle("j_jmp",   OP_J, 1'b0, 1'b1, C_JMP);
        check_val("j_cnt", Instr_Count, 32'd5);

        // addi.
        run_cycle("ai_fetch", OP_ADDI, 1'b0, 1'b1, C_FETCH);
        run_cycle("ai_dec",   OP_ADDI, 1'b0, 1'b1, C_DEC);
        run_cycle("ai_ex",    OP_ADDI, 1'b0, 1'b1, C_AEX);
        run_cycle("ai_wb",    OP_ADDI, 1'b0, 1'b1, C_AWB);
        check_val("ai_cnt", Instr_Count, 32'd6);

        // sw with one FETCH wait cycle first.
        run_cycle("sw_fwait", OP_SW, 1'b0, 1'b0, C_FETCHW);
        run_cycle("sw_fetch", OP_SW, 1'b0, 1'b1, C_FETCH);
        run_cycle("sw_dec",   OP_SW, 1'b0, 1'b1, C_DEC);
        run_cycle("sw_addr",  OP_SW, 1'b0, 1'b1, C_MADDR);
        run_cycle("sw_wr",    OP_SW, 1'b0, 1'b1, C_MWR);
        check_val("sw_cnt", Instr_Count, 32'd7);

        // sw timeout: four wait cycles, fault on the fifth, no retire.
        run_cycle("swf_fetch", OP_SW, 1'b0, 1'b1, C_FETCH);
        run_cycle("swf_dec",   OP_SW, 1'b0, 1'b1, C_DEC);
        run_cycle("swf_addr",  OP_SW, 1'b0, 1'b1, C_MADDR);
        for (int i = 0; i < 4; i++) begin
            run_cycle("swf_wait", OP_SW, 1'b0, 1'b0, C_MWR);
        end
        Mem_Ready = 1'b0;
        #1;
        check_val("swf_fault", {31'd0, Mem_Fault}, 32'd1);
        check_val("swf_nowr",  {31'd0, Mem_Write}, 32'd0);
        @(posedge Clock); #1;
        run_cycle("swf_back", OP_SW, 1'b0, 1'b1, C_FETCH);
        check_val("swf_cnt", Instr_Count, 32'd7);

        // Mem_Ready arriving on the limit cycle wins over the timeout.
        run_cycle("swr_dec",  OP_SW, 1'b0, 1'b1, C_DEC);
        run_cycle("swr_addr", OP_SW, 1'b0, 1'b1, C_MADDR);
        for (int i = 0; i < 4; i++) begin
            run_cycle("swr_wait", OP_SW, 1'b0, 1'b0, C_MWR);
        end
        run_cycle("swr_last", OP_SW, 1'b0, 1'b1, C_MWR);
        check_val("swr_cnt", Instr_Count, 32'd8);

        // Reset low while waiting in MEM_RD aborts the load and clears the count.
        run_cycle("lwa_fetch", OP_LW, 1'b0, 1'b1, C_FETCH);
        run_cycle("lwa_dec",   OP_LW, 1'b0, 1'b1, C_DEC);
        run_cycle("lwa_addr",  OP_LW, 1'b0, 1'b1, C_MADDR);
        run_cycle("lwa_wait1", OP_LW, 1'b0, 1'b0, C_MRD);
        run_cycle("lwa_wait2", OP_LW, 1'b0, 1'b0, C_MRD);
        Reset = 1'b0;
        #1;
        check_val("lwa_rst", {15'd0, ctl}, 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b1;
        check_val("lwa_cnt", Instr_Count, 32'd0);
        run_cycle("lwa_fetch2", OP_J, 1'b0, 1'b1, C_FETCH);
        run_cycle("lwa_dec2",   OP_J, 1'b0, 1'b1, C_DEC);
        run_cycle("lwa_jmp",    OP_J, 1'b0, 1'b1, C_JMP);
        check_val("lwa_cnt2", Instr_Count, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
